mdio_target: RTL and testbench

- PHY-side MDIO management target; sits directly downstream of the MDIO controller (generator) and consumes its mdc / mdio_out / mdio_oe.
- Deserialises 32-bit Clause-22 frames, MSB first: ST(2) OP(2) PHYADR(5) REGADR(5) TA(2) DATA(16).
- Writes: issues a write to an external 32x16 register bank.
- Reads: fetches a register and serialises it back on mdio_in for the controller to capture.

---
 rtl/mdio_pkg.sv | 38 +++
 rtl/mdio_edge_det.sv | 29 ++
 rtl/mdio_target.sv | 166 ++++++++++++++++
 tb/tb_mdio_target.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause-22 definitions: FSM states, frame codes, header field positions.
// Used by the target, its edge detector and benches.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    TA,
    WDATA,
    RDATA,
    DISCARD
  } state_t;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // bit_cnt values (1-based) at the last header, TA and frame bit
  localparam logic [5:0] HDR_BITS   = 6'd14;
  localparam logic [5:0] TA_LAST    = 6'd16;
  localparam logic [5:0] FRAME_BITS = 6'd32;

  // positions inside the 14-bit header word, MSB first on the wire
  localparam int HDR_W   = 14;
  localparam int ST_MSB  = 13;
  localparam int OP_MSB  = 11;
  localparam int PHY_MSB = 9;
  localparam int REG_MSB = 4;

  function automatic logic frame_ok(
    input logic [1:0] st,
    input logic [1:0] op
  );
    return (st == ST_CODE) &&
           (op == OP_WRITE || op == OP_READ);
  endfunction

endpackage

// File: rtl/mdio_edge_det.sv
// Registers mdc into the clk domain and emits one-clk rise/fall pulses.
// Ports: i_clk, i_rst (async high), i_mdc in; o_rise, o_fall out.
module mdio_edge_det #(
  parameter int MIN_HALF = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_mdc,
  output logic o_rise,
  output logic o_fall
);

  logic r_mdc_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_mdc_q <= 1'b0;
    else       r_mdc_q <= i_mdc;
  end

  assign o_rise = i_mdc & ~r_mdc_q;
  assign o_fall = ~i_mdc & r_mdc_q;

  // mdc must sit in each level for at least MIN_HALF clk samples
  a_high_min: assert property (@(posedge i_clk) disable iff (i_rst)
    o_fall |-> $past(i_mdc, MIN_HALF));
  a_low_min: assert property (@(posedge i_clk) disable iff (i_rst)
    o_rise |-> !$past(i_mdc, MIN_HALF));

endmodule

// File: rtl/mdio_target.sv
// MDIO Clause-22 PHY-side target: decodes frames, strobes an external 32x16
// register bank and serialises read data back on mdio_in.
// Ports: clk, reset (async high), mdc, mdio_oe, mdio_out, mem_rd_data in;
// mdio_in, mem_addr, mem_wr_data, mem_write, mem_read, frame_err, busy out.
// Define MDIO_PHYADDR_FILTER_EN to drop frames whose PHYADR != PHY_ADDR.
module mdio_target
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         MDC_MIN_HALF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_oe,
  input  logic        mdio_out,
  output logic        mdio_in,
  output logic [4:0]  mem_addr,
  output logic [15:0] mem_wr_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [15:0] mem_rd_data,
  output logic        frame_err,
  output logic        busy
);

`ifdef MDIO_PHYADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  state_t            r_state, w_next;
  logic [5:0]        r_bit_cnt;
  logic [HDR_W-2:0]  r_hdr;
  logic [15:0]       r_tx_sr;
  logic              r_is_read;
  logic              r_rd_cap;

  logic              w_rise, w_fall;
  logic [HDR_W-1:0]  w_hdr;
  logic [1:0]        w_st, w_op;
  logic [4:0]        w_phy, w_reg;
  logic              w_phy_ok;
  logic              w_hdr_end, w_ta_end, w_last;
  logic              w_err;

  mdio_edge_det #(
    .MIN_HALF (MDC_MIN_HALF)
  ) u_edge (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_mdc  (mdc),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // header including the bit arriving on this rise
  assign w_hdr = {r_hdr, mdio_out};
  assign w_st  = w_hdr[ST_MSB -: 2];
  assign w_op  = w_hdr[OP_MSB -: 2];
  assign w_phy = w_hdr[PHY_MSB -: 5];
  assign w_reg = w_hdr[REG_MSB -: 5];

  assign w_phy_ok  = !FILTER_EN || (w_phy == PHY_ADDR);
  assign w_hdr_end = w_rise && (r_bit_cnt == HDR_BITS - 6'd1);
  assign w_ta_end  = w_rise && (r_bit_cnt == TA_LAST - 6'd1);
  assign w_last    = w_rise && (r_bit_cnt == FRAME_BITS - 6'd1);

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise && mdio_oe) w_next = HEADER;
      end
      HEADER: begin
        if (!mdio_oe) begin
          w_next = IDLE;
          w_err  = 1'b1;
        end else if (w_hdr_end) begin
          if (!w_phy_ok) begin
            w_next = DISCARD;
          end else if (!frame_ok(w_st, w_op)) begin
            w_next = DISCARD;
            w_err  = 1'b1;
          end else begin
            w_next = TA;
          end
        end
      end
      TA: begin
        if (w_ta_end) w_next = r_is_read ? RDATA : WDATA;
      end
      WDATA: begin
        if (!mdio_oe) begin
          w_next = IDLE;
          w_err  = 1'b1;
        end else if (w_last) begin
          w_next = IDLE;
        end
      end
      RDATA, DISCARD: begin
        if (w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdio_in     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      frame_err   <= 1'b0;
      r_bit_cnt   <= '0;
      r_hdr       <= '0;
      r_tx_sr     <= '0;
      r_is_read   <= 1'b0;
      r_rd_cap    <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      frame_err <= w_err;
      // read data is valid the clk after the mem_read strobe
      r_rd_cap  <= mem_read;

      if (w_next == IDLE)
        r_bit_cnt <= '0;
      else if (w_rise)
        r_bit_cnt <= r_bit_cnt + 6'd1;

      if (w_rise && (r_state == IDLE || r_state == HEADER))
        r_hdr <= w_hdr[HDR_W-2:0];

      if (r_state == HEADER && w_next == TA) begin
        mem_addr  <= w_reg;
        r_is_read <= (w_op == OP_READ);
        mem_read  <= (w_op == OP_READ);
      end

      if (r_state == WDATA && w_rise && mdio_oe) begin
        mem_wr_data <= {mem_wr_data[14:0], mdio_out};
        mem_write   <= w_last;
      end

      if (w_fall) begin
        mdio_in <= (r_state == RDATA) ? r_tx_sr[15] : 1'b0;
        if (r_state == RDATA)
          r_tx_sr <= {r_tx_sr[14:0], 1'b0};
      end

      if (r_rd_cap) r_tx_sr <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_mdio_target.sv
// Directed bench for mdio_target: bit-bangs Clause-22 frames on mdc/mdio
// and checks strobes, read serialisation, errors, aborts and reset.
module tb_mdio_target;

  localparam int H = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdc = 1'b0;
  logic        mdio_oe = 1'b0;
  logic        mdio_out = 1'b0;
  logic        mdio_in;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wr_data;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_rd_data = 16'hDEAD;
  logic        frame_err;
  logic        busy;

  logic [15:0] rd_val = 16'h0000;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;
  int cur_bit = 0;
  int err_bit = 0;
  logic [4:0]  wr_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [15:0] wr_data = '0;

  mdio_target #(
    .PHY_ADDR     (5'd1),
    .MDC_MIN_HALF (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mdc         (mdc),
    .mdio_oe     (mdio_oe),
    .mdio_out    (mdio_out),
    .mdio_in     (mdio_in),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_rd_data (mem_rd_data),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // register bank: data valid the clk after mem_read, junk otherwise
  always @(posedge clk)
    mem_rd_data <= mem_read ? rd_val : 16'hDEAD;

  always @(negedge clk) begin
    if (mem_write) begin
      n_wr++;
      wr_addr = mem_addr;
      wr_data = mem_wr_data;
    end
    if (mem_read) begin
      n_rd++;
      rd_addr = mem_addr;
    end
    if (frame_err) begin
      n_err++;
      err_bit = cur_bit;
    end
    if (mem_write && mem_read) n_both++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input  logic [31:0] f,
                            input  bit          rd,
                            input  int          drop,
                            input  int          nbits,
                            output logic [31:0] rx,
                            output logic        b32);
    rx  = '0;
    b32 = 1'b0;
    for (int k = 1; k <= nbits; k++) begin
      @(negedge clk);
      cur_bit  = k;
      mdc      = 1'b0;
      mdio_oe  = !((rd && k > 14) || (drop != 0 && k >= drop));
      mdio_out = mdio_oe ? f[32-k] : 1'b0;
      if (k == 32) b32 = busy;
      repeat (H - 1) @(negedge clk);
      @(negedge clk);
      mdc = 1'b1;
      rx  = {rx[30:0], mdio_in};
      repeat (H - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mdc      = 1'b0;
    mdio_oe  = 1'b0;
    mdio_out = 1'b0;
    cur_bit  = 0;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] rx;
  logic        b32;
  int          b_wr, b_rd, b_err;

  task automatic snap();
    b_wr  = n_wr;
    b_rd  = n_rd;
    b_err = n_err;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {mdio_in, mem_addr, mem_wr_data, mem_write,
         mem_read, frame_err, busy}, 32'd0);
    reset = 1'b0;
    idle(4);

    // write BEEF to reg 3, then a read with zero idle bits between
    snap();
    send_frame(32'h508EBEEF, 1'b0, 0, 32, rx, b32);
    chk("wr_count", n_wr - b_wr, 1);
    chk("wr_addr", wr_addr, 5'd3);
    chk("wr_data", wr_data, 16'hBEEF);
    chk("wr_err", n_err - b_err, 0);
    chk("wr_no_rd", n_rd - b_rd, 0);
    chk("wr_busy_b32", b32, 1'b1);
    chk("wr_busy_end", busy, 1'b0);

    snap();
    rd_val = 16'h1234;
    send_frame(32'h60940000, 1'b1, 0, 32, rx, b32);
    idle(2 * H);
    chk("rd_count", n_rd - b_rd, 1);
    chk("rd_addr", rd_addr, 5'd5);
    chk("rd_data", rx[15:0], 16'h1234);
    chk("rd_ta_zero", rx[17:16], 2'b00);
    chk("rd_no_wr", n_wr - b_wr, 0);
    chk("rd_err", n_err - b_err, 0);
    chk("rd_mdio_idle", mdio_in, 1'b0);
    chk("rd_busy_end", busy, 1'b0);

    // bad opcode
    snap();
    send_frame(32'h408E0000, 1'b0, 0, 32, rx, b32);
    chk("bad_err", n_err - b_err, 1);
    chk("bad_err_bit", err_bit, 14);
    chk("bad_strobes", (n_wr - b_wr) + (n_rd - b_rd), 0);
    chk("bad_busy_b32", b32, 1'b1);
    chk("bad_busy_end", busy, 1'b0);
    idle(4);

    // foreign PHY address
    snap();
    send_frame(32'h510EBEEF, 1'b0, 0, 32, rx, b32);
    chk("flt_err", n_err - b_err, 0);
    chk("flt_no_rd", n_rd - b_rd, 0);
`ifdef MDIO_PHYADDR_FILTER_EN
    chk("flt_no_wr", n_wr - b_wr, 0);
`else
    chk("flt_wr", n_wr - b_wr, 1);
    chk("flt_wr_addr", wr_addr, 5'd3);
    chk("flt_wr_data", wr_data, 16'hBEEF);
`endif
    chk("flt_busy_end", busy, 1'b0);
    idle(4);

    // reset after bit 20 of a write
    snap();
    send_frame(32'h508EBEEF, 1'b0, 0, 20, rx, b32);
    chk("pre_rst_addr", mem_addr, 5'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs",
        {mdio_in, mem_addr, mem_wr_data, mem_write,
         mem_read, frame_err, busy}, 32'd0);
    idle(3);
    reset = 1'b0;
    idle(4);
    chk("rst_no_wr", n_wr - b_wr, 0);
    snap();
    send_frame(32'h50861357, 1'b0, 0, 32, rx, b32);
    chk("rst_next_wr", n_wr - b_wr, 1);
    chk("rst_next_addr", wr_addr, 5'd1);
    chk("rst_next_data", wr_data, 16'h1357);
    idle(4);

    // controller drops oe at bit 10 of a write
    snap();
    send_frame(32'h508EBEEF, 1'b0, 10, 32, rx, b32);
    chk("oe_err", n_err - b_err, 1);
    chk("oe_err_bit", err_bit, 10);
    chk("oe_no_wr", n_wr - b_wr, 0);
    chk("oe_busy_end", busy, 1'b0);
    idle(4);

    chk("wr_rd_overlap", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
